// File: rtl/cordic_vector.sv
// cordic_vector: iterative vectoring-mode CORDIC returning atan2(y, x) as a binary
// angle (2^32 = 360 deg) and the K-scaled vector magnitude, one micro-rotation per cycle.
//
// state  | meaning
// IDLE   | waiting for start; inputs latched on acceptance
// PREROT | fold left half-plane onto right half-plane, seed z
// ITER   | one shift-add micro-rotation per cycle, i = 0..ITERATIONS-1
// DONE   | one-cycle done pulse; start here chains the next conversion
module cordic_vector #(
  parameter int ITERATIONS = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] x_in,
  input  logic [31:0] y_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] angle,
  output logic [31:0] magnitude
);

  typedef enum logic [1:0] {IDLE = 2'd0, PREROT = 2'd1, ITER = 2'd2, DONE = 2'd3} state_t;

  // round(atan(2^-i) * 2^32 / (2*pi))
  function automatic logic [31:0] atan_rom(input logic [4:0] idx);
    case (idx)
      5'd0:  return 32'h2000_0000;
      5'd1:  return 32'h12E4_051E;
      5'd2:  return 32'h09FB_385B;
      5'd3:  return 32'h0511_11D4;
      5'd4:  return 32'h028B_0D43;
      5'd5:  return 32'h0145_D7E1;
      5'd6:  return 32'h00A2_F61E;
      5'd7:  return 32'h0051_7C55;
      5'd8:  return 32'h0028_BE53;
      5'd9:  return 32'h0014_5F2F;
      5'd10: return 32'h000A_2F98;
      5'd11: return 32'h0005_17CC;
      5'd12: return 32'h0002_8BE6;
      5'd13: return 32'h0001_45F3;
      5'd14: return 32'h0000_A2FA;
      5'd15: return 32'h0000_517D;
      5'd16: return 32'h0000_28BE;
      5'd17: return 32'h0000_145F;
      5'd18: return 32'h0000_0A30;
      5'd19: return 32'h0000_0518;
      5'd20: return 32'h0000_028C;
      5'd21: return 32'h0000_0146;
      5'd22: return 32'h0000_00A3;
      5'd23: return 32'h0000_0051;
      5'd24: return 32'h0000_0029;
      5'd25: return 32'h0000_0014;
      5'd26: return 32'h0000_000A;
      5'd27: return 32'h0000_0005;
      5'd28: return 32'h0000_0003;
      5'd29: return 32'h0000_0001;
      5'd30: return 32'h0000_0001;
      default: return 32'h0000_0000;
    endcase
  endfunction

  state_t             state, state_nxt;
  logic signed [33:0] x_r, y_r, x_sh, y_sh, x_nxt, y_nxt;
  logic        [31:0] z_r, z_nxt;
  logic        [4:0]  cnt;
  logic               zero_r;
  logic               last;

  assign last = (cnt == 5'(ITERATIONS - 1));
  assign busy = (state == PREROT) || (state == ITER);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = PREROT;
      PREROT:  state_nxt = ITER;
      ITER:    if (last) state_nxt = DONE;
      DONE:    state_nxt = start ? PREROT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Both updates use the pre-update x and y; rotate toward y = 0.
  always_comb begin
    x_sh  = x_r >>> cnt;
    y_sh  = y_r >>> cnt;
    x_nxt = x_r;
    y_nxt = y_r;
    z_nxt = z_r;
    if (!y_r[33]) begin
      x_nxt = x_r + y_sh;
      y_nxt = y_r - x_sh;
      z_nxt = z_r + atan_rom(cnt);
    end else begin
      x_nxt = x_r - y_sh;
      y_nxt = y_r + x_sh;
      z_nxt = z_r - atan_rom(cnt);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_r       <= '0;
      y_r       <= '0;
      z_r       <= '0;
      cnt       <= '0;
      zero_r    <= 1'b0;
      angle     <= '0;
      magnitude <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            x_r    <= {{2{x_in[31]}}, x_in};
            y_r    <= {{2{y_in[31]}}, y_in};
            zero_r <= (x_in == 32'd0) && (y_in == 32'd0);
          end
        end
        PREROT: begin
          if (x_r[33]) begin
            x_r <= -x_r;
            y_r <= -y_r;
            z_r <= 32'h8000_0000;
          end else begin
            z_r <= 32'h0000_0000;
          end
          cnt <= '0;
        end
        ITER: begin
          x_r <= x_nxt;
          y_r <= y_nxt;
          z_r <= z_nxt;
          cnt <= cnt + 5'd1;
          if (last) begin
            angle     <= zero_r ? 32'd0 : z_nxt;
            magnitude <= zero_r ? 32'd0 :
                         (|x_nxt[33:31]) ? 32'h7FFF_FFFF : x_nxt[31:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
